// File: rtl/mem_copy_scheduler.sv
// Round-robin scheduler that lends one copy engine and detector pair to NUM_REQ requesters.
// Latency: grant one cycle after req is sampled, copy_start CLEAR_CYCLES+1 cycles after it, done one cycle after transfer_done.
// Backpressure: req is a level held by the requester; losers wait in IDLE until the current transaction is released.
module mem_copy_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = 2,
    parameter int CLEAR_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    active_id,
    output logic               busy,
    output logic               det_enable,
    output logic               copy_start,
    input  logic               transfer_done,
    output logic [NUM_REQ-1:0] done,
    output logic               timeout_err
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_START   = 3'd2,
        ST_WAIT    = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CLEAR_LAST   = CNT_W'(CLEAR_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [ID_W-1:0]    rr_ptr, rr_ptr_n;
    logic [NUM_REQ-1:0] grant_n, done_n;
    logic [ID_W-1:0]    active_id_n;
    logic               busy_n, det_enable_n, copy_start_n, timeout_err_n;

    logic               found;
    logic [ID_W-1:0]    winner;
    int                 scan;

    // Round-robin search: first asserted req starting just after the last winner.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        scan   = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            scan = (int'(rr_ptr) + i) % NUM_REQ;
            if (!found && req[scan]) begin
                found  = 1'b1;
                winner = ID_W'(scan);
            end
        end
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        rr_ptr_n      = rr_ptr;
        grant_n       = grant;
        active_id_n   = active_id;
        busy_n        = busy;
        det_enable_n  = det_enable;
        copy_start_n  = 1'b0;
        done_n        = '0;
        timeout_err_n = 1'b0;
        unique case (state)
            ST_IDLE: begin
                det_enable_n = 1'b1;
                busy_n       = 1'b0;
                if (found) begin
                    grant_n     = NUM_REQ'(1) << winner;
                    active_id_n = winner;
                    rr_ptr_n    = winner;
                    busy_n      = 1'b1;
                    cnt_n       = '0;
                    state_n     = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                det_enable_n = 1'b1;
                if (cnt == CLEAR_LAST) begin
                    state_n      = ST_START;
                    copy_start_n = 1'b1;
                    det_enable_n = 1'b0;
                    cnt_n        = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_START: begin
                state_n      = ST_WAIT;
                det_enable_n = 1'b0;
                cnt_n        = '0;
            end
            ST_WAIT: begin
                det_enable_n = 1'b0;
                cnt_n        = cnt + 1'b1;
                // A completion on the timeout edge still counts as a completion.
                if (transfer_done) begin
                    done_n       = NUM_REQ'(1) << active_id;
                    grant_n      = '0;
                    det_enable_n = 1'b1;
                    state_n      = ST_RELEASE;
                end else if (cnt == TIMEOUT_LAST) begin
                    timeout_err_n = 1'b1;
                    grant_n       = '0;
                    det_enable_n  = 1'b1;
                    state_n       = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                det_enable_n = 1'b1;
                busy_n       = 1'b0;
                state_n      = ST_IDLE;
            end
            default: begin
                state_n      = ST_IDLE;
                grant_n      = '0;
                busy_n       = 1'b0;
                det_enable_n = 1'b1;
            end
        endcase
    end

    // State and output registers; reset leaves requester 0 with top priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            rr_ptr      <= ID_W'(NUM_REQ - 1);
            grant       <= '0;
            active_id   <= '0;
            busy        <= 1'b0;
            det_enable  <= 1'b1;
            copy_start  <= 1'b0;
            done        <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            rr_ptr      <= rr_ptr_n;
            grant       <= grant_n;
            active_id   <= active_id_n;
            busy        <= busy_n;
            det_enable  <= det_enable_n;
            copy_start  <= copy_start_n;
            done        <= done_n;
            timeout_err <= timeout_err_n;
        end
    end

endmodule

// File: tb/tb_mem_copy_scheduler.sv
// Randomized bench for mem_copy_scheduler against a transaction-level reference model.
// Latency: checks every cycle of each transaction against the expected timeline.
// Backpressure: req is randomized after grant to confirm it is ignored until release.
module tb_mem_copy_scheduler;

    localparam int N = 4;
    localparam int C = 2;
    localparam int T = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] req;
    logic [N-1:0] grant;
    logic [1:0]   active_id;
    logic         busy;
    logic         det_enable;
    logic         copy_start;
    logic         transfer_done;
    logic [N-1:0] done;
    logic         timeout_err;

    int errors = 0;
    int checks = 0;
    int ptr    = N - 1;   // model: last granted requester

    mem_copy_scheduler #(
        .NUM_REQ(N), .ID_W(2), .CLEAR_CYCLES(C), .TIMEOUT_CYCLES(T), .CNT_W(10)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .grant(grant), .active_id(active_id),
        .busy(busy), .det_enable(det_enable), .copy_start(copy_start),
        .transfer_done(transfer_done), .done(done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // exp_id < 0 skips the active_id comparison.
    task automatic check_outs(input string tag, input int exp_grant, input int exp_id,
                              input int exp_busy, input int exp_det, input int exp_cs,
                              input int exp_done, input int exp_to);
        check({tag, ".grant"}, 32'(grant), 32'(exp_grant));
        if (exp_id >= 0) check({tag, ".active_id"}, 32'(active_id), 32'(exp_id));
        check({tag, ".busy"}, 32'(busy), 32'(exp_busy));
        check({tag, ".det_enable"}, 32'(det_enable), 32'(exp_det));
        check({tag, ".copy_start"}, 32'(copy_start), 32'(exp_cs));
        check({tag, ".done"}, 32'(done), 32'(exp_done));
        check({tag, ".timeout_err"}, 32'(timeout_err), 32'(exp_to));
    endtask

    // Reference arbitration: scan ptr+1, ptr+2, ... modulo N.
    function automatic int pick(input logic [N-1:0] p);
        for (int i = 1; i <= N; i++) begin
            if (p[(ptr + i) % N]) return (ptr + i) % N;
        end
        return -1;
    endfunction

    // Runs one transaction starting from an IDLE cycle. d = WAIT cycle in which
    // transfer_done is driven (d > T means never, i.e. timeout). stale drives
    // transfer_done high outside WAIT. rst_at > 0 applies reset in that WAIT cycle.
    task automatic run_txn(input logic [N-1:0] pat, input int d, input bit stale, input int rst_at);
        int  w;
        int  g;
        bit  fin;
        w = pick(pat);
        g = 1 << w;
        ptr = w;
        req = pat;
        transfer_done = stale ? 1'b1 : 1'($urandom);
        tick();
        for (int c = 1; c <= C; c++) begin
            check_outs($sformatf("clear%0d", c), g, w, 1, 1, 0, 0, 0);
            req = N'($urandom);
            transfer_done = stale ? 1'b1 : 1'($urandom);
            tick();
        end
        check_outs("start", g, w, 1, 0, 1, 0, 0);
        req = N'($urandom);
        transfer_done = stale ? 1'b1 : 1'($urandom);
        tick();
        fin = 1'b0;
        for (int k = 1; k <= T && !fin; k++) begin
            check_outs($sformatf("wait%0d", k), g, w, 1, 0, 0, 0, 0);
            if (k == rst_at) begin
                reset = 1'b1;
                req = N'($urandom);
                transfer_done = 1'($urandom);
                tick();
                check_outs("midreset", 0, 0, 0, 1, 0, 0, 0);
                reset = 1'b0;
                req = '0;
                transfer_done = 1'b0;
                ptr = N - 1;
                return;
            end
            transfer_done = (k == d);
            if (k == d || k == T) fin = 1'b1;
            req = N'($urandom);
            tick();
        end
        if (d <= T) check_outs("release_done", 0, -1, 1, 1, 0, g, 0);
        else        check_outs("release_timeout", 0, -1, 1, 1, 0, 0, 1);
        req = N'($urandom);
        transfer_done = stale ? 1'b1 : 1'($urandom);
        tick();
        check_outs("idle", 0, -1, 0, 1, 0, 0, 0);
    endtask

    initial begin
        logic [N-1:0] p;
        int d;
        reset = 1'b1;
        req = '0;
        transfer_done = 1'b0;

        // Reset with random inputs
        for (int i = 0; i < 2; i++) begin
            req = N'($urandom);
            transfer_done = 1'($urandom);
            tick();
            check_outs("reset", 0, 0, 0, 1, 0, 0, 0);
        end
        reset = 1'b0;
        req = '0;
        transfer_done = 1'b0;
        tick();
        check_outs("post_reset_idle", 0, 0, 0, 1, 0, 0, 0);

        // Single request, completion in WAIT cycle 4
        run_txn(4'b0100, 4, 1'b0, 0);

        // Round-robin with all requesters active
        for (int i = 0; i < 5; i++) run_txn(4'b1111, 3, 1'b0, 0);

        // Timeout, then completion on the timeout edge
        run_txn(4'b0001, T + 1, 1'b0, 0);
        run_txn(4'b0001, T, 1'b0, 0);

        // Stale transfer_done outside WAIT
        run_txn(4'b0010, 5, 1'b1, 0);

        // Reset in mid-WAIT, then priority restarts at requester 0
        run_txn(4'b1000, 10, 1'b0, 2);
        run_txn(4'b1111, 2, 1'b0, 0);

        // Random traffic
        for (int i = 0; i < 40; i++) begin
            p = N'($urandom_range(1, 15));
            d = $urandom_range(1, T + 3);
            run_txn(p, d, 1'($urandom), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
